// File: rtl/qdr_user_arb_pkg.sv
// Shared constants and helpers for the QDRII+ user-interface arbiter.
// The round-robin search is shared by the write and read arbiters.
package qdr_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } rr_win_t;

  function automatic int udw(input int burst_len, input int data_width);
    return burst_len * data_width;
  endfunction

  function automatic int bww(input int burst_len, input int bw_width);
    return burst_len * bw_width;
  endfunction

  function automatic int tag_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // First set request at or above ptr, wrapping at n.
  function automatic rr_win_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0] ptr, input int n);
    rr_win_t w;
    int      j;
    w = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !w.hit) begin
        j = (int'(ptr) + k) % n;
        if (req[3'(j)]) begin
          w.hit = 1'b1;
          w.idx = 3'(j);
        end
      end
    end
    return w;
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/qdr_user_arb_if.sv
// MIG user-interface command/data channel between the arbiter and example_top.
interface qdr_user_arb_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int UDW        = 144,
  parameter int BWW        = 16
);
  logic                  app_wr_cmd;
  logic [ADDR_WIDTH-1:0] app_wr_addr;
  logic [UDW-1:0]        app_wr_data;
  logic [BWW-1:0]        app_wr_bw_n;
  logic                  app_rd_cmd;
  logic [ADDR_WIDTH-1:0] app_rd_addr;
  logic                  app_rd_valid;
  logic [UDW-1:0]        app_rd_data;

  modport master (
    output app_wr_cmd, app_wr_addr, app_wr_data, app_wr_bw_n,
    output app_rd_cmd, app_rd_addr,
    input  app_rd_valid, app_rd_data
  );

  modport slave (
    input  app_wr_cmd, app_wr_addr, app_wr_data, app_wr_bw_n,
    input  app_rd_cmd, app_rd_addr,
    output app_rd_valid, app_rd_data
  );
endinterface

// File: rtl/qdr_user_arb_tag_fifo.sv
// Synchronous tag FIFO with registered full/empty; first-word fall-through output.
module qdr_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_push, do_pop;

  // A pop while full frees the slot being written, so push is still legal.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/qdr_user_arb.sv
// Shares the QDRII+ MIG user interface between NUM_REQ requesters with independent
// round-robin write/read arbiters. Optional counters: QDR_USER_ARB_PERF_EN.
module qdr_user_arb
  import qdr_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 36,
  parameter int BW_WIDTH       = 4,
  parameter int BURST_LEN      = 4,
  parameter int RD_OUTSTANDING = 16,
  localparam int UDW   = udw(BURST_LEN, DATA_WIDTH),
  localparam int BWW   = bww(BURST_LEN, BW_WIDTH),
  localparam int TAG_W = tag_w(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          cal_done,
  input  logic [NUM_REQ-1:0]            wr_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*UDW-1:0]        wr_data,
  input  logic [NUM_REQ*BWW-1:0]        wr_bw_n,
  output logic [NUM_REQ-1:0]            wr_ready,
  input  logic [NUM_REQ-1:0]            rd_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_ready,
  output logic [UDW-1:0]                rd_data,
  output logic [NUM_REQ-1:0]            rd_data_valid,
  qdr_user_arb_if.master                app,
  output logic                          tag_err
`ifdef QDR_USER_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [31:0]                   perf_wr_cnt,
  output logic [31:0]                   perf_rd_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_addr_a, rd_addr_a;
  logic [NUM_REQ-1:0][UDW-1:0]        wr_data_a;
  logic [NUM_REQ-1:0][BWW-1:0]        wr_bw_a;

  assign wr_addr_a = wr_addr;
  assign rd_addr_a = rd_addr;
  assign wr_data_a = wr_data;
  assign wr_bw_a   = wr_bw_n;

  logic [MAX_REQ-1:0]    wr_req, rd_req;
  logic [2:0]            wr_ptr, rd_ptr;
  rr_win_t               wr_win, rd_win;
  logic                  arb_en, wr_go, rd_go;
  logic                  fifo_full, fifo_empty, rd_pop;
  logic [TAG_W-1:0]      pop_tag;
  logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
  logic [UDW-1:0]        wr_data_sel;
  logic [BWW-1:0]        wr_bw_sel;

  always_comb begin
    wr_req      = '0;
    rd_req      = '0;
    wr_addr_sel = '0;
    rd_addr_sel = '0;
    wr_data_sel = '0;
    wr_bw_sel   = '1;
    wr_ready    = '0;
    rd_ready    = '0;
    wr_req[NUM_REQ-1:0] = wr_valid;
    rd_req[NUM_REQ-1:0] = rd_valid;
    wr_win = rr_pick(wr_req, wr_ptr, NUM_REQ);
    rd_win = rr_pick(rd_req, rd_ptr, NUM_REQ);
    arb_en = cal_done & ~sys_rst;
    wr_go  = arb_en & wr_win.hit;
    // Registered full: a same-cycle pop does not open a slot until next cycle.
    rd_go  = arb_en & rd_win.hit & ~fifo_full;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_ready[i] = wr_go && (wr_win.idx == 3'(i));
      rd_ready[i] = rd_go && (rd_win.idx == 3'(i));
      if (wr_win.idx == 3'(i)) begin
        wr_addr_sel = wr_addr_a[i];
        wr_data_sel = wr_data_a[i];
        wr_bw_sel   = wr_bw_a[i];
      end
      if (rd_win.idx == 3'(i)) rd_addr_sel = rd_addr_a[i];
    end
  end

  assign rd_pop = app.app_rd_valid & ~fifo_empty;

  qdr_arb_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (RD_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (rd_go),
    .din   (rd_win.idx[TAG_W-1:0]),
    .pop   (rd_pop),
    .dout  (pop_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      app.app_wr_cmd  <= 1'b0;
      app.app_wr_addr <= '0;
      app.app_wr_data <= '0;
      app.app_wr_bw_n <= '1;
      app.app_rd_cmd  <= 1'b0;
      app.app_rd_addr <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rd_data         <= '0;
      rd_data_valid   <= '0;
      tag_err         <= 1'b0;
    end else begin
      app.app_wr_cmd <= wr_go;
      if (wr_go) begin
        app.app_wr_addr <= wr_addr_sel;
        app.app_wr_data <= wr_data_sel;
        app.app_wr_bw_n <= wr_bw_sel;
        wr_ptr          <= rr_next(wr_win.idx, NUM_REQ);
      end
      app.app_rd_cmd <= rd_go;
      if (rd_go) begin
        app.app_rd_addr <= rd_addr_sel;
        rd_ptr          <= rr_next(rd_win.idx, NUM_REQ);
      end
      if (rd_pop) rd_data <= app.app_rd_data;
      for (int i = 0; i < NUM_REQ; i++)
        rd_data_valid[i] <= rd_pop && (pop_tag == TAG_W'(i));
      // Data with no tag outstanding cannot be steered; flag it until reset.
      if (app.app_rd_valid && fifo_empty) tag_err <= 1'b1;
    end
  end

`ifdef QDR_USER_ARB_PERF_EN
  logic rd_stall;
  assign rd_stall = (|rd_valid) & (~cal_done | fifo_full);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || perf_clr) begin
      perf_wr_cnt    <= '0;
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (app.app_wr_cmd && !(&perf_wr_cnt)) perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (app.app_rd_cmd && !(&perf_rd_cnt)) perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (rd_stall && !(&perf_stall_cnt))    perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qdr_user_arb.sv
// Randomized + directed bench for qdr_user_arb against a cycle-level reference model.
module tb_qdr_user_arb;
  localparam int N   = 2;
  localparam int AW  = 18;
  localparam int UDW = 144;
  localparam int BWW = 16;
  localparam int RDO = 16;

  logic               sys_clk = 1'b0;
  logic               sys_rst, cal_done, tag_err;
  logic [N-1:0]       wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid;
  logic [N*AW-1:0]    wr_addr, rd_addr;
  logic [N*UDW-1:0]   wr_data;
  logic [N*BWW-1:0]   wr_bw_n;
  logic [UDW-1:0]     rd_data;

  qdr_user_arb_if #(.ADDR_WIDTH(AW), .UDW(UDW), .BWW(BWW)) app ();

`ifdef QDR_USER_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_wr_cnt, perf_rd_cnt, perf_stall_cnt;
`endif

  qdr_user_arb #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(36), .BW_WIDTH(4),
    .BURST_LEN(4), .RD_OUTSTANDING(RDO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cal_done(cal_done),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bw_n(wr_bw_n),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .app(app), .tag_err(tag_err)
`ifdef QDR_USER_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester payloads (held until granted)
  logic [N-1:0]   r_wv, r_rv;
  logic [AW-1:0]  r_wa [N];
  logic [AW-1:0]  r_ra [N];
  logic [UDW-1:0] r_wd [N];
  logic [BWW-1:0] r_wb [N];
  logic           mig_rv;
  logic [UDW-1:0] mig_rd;

  // reference model state
  int             m_wp, m_rp;
  int             tagq[$];
  logic           e_wcmd, e_rcmd, e_terr;
  logic [AW-1:0]  e_wa, e_ra;
  logic [UDW-1:0] e_wd, e_rdata;
  logic [BWW-1:0] e_wb;
  logic [N-1:0]   e_rdv;

  // last observed DUT values, for directed checks
  logic [N-1:0]   o_wr_ready, o_rd_ready, o_rdv;
  logic           o_wcmd, o_rcmd, o_terr;
  logic [UDW-1:0] o_rdata;

  function automatic logic [UDW-1:0] rnd_udw();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[UDW-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] o;
    o = '0;
    if (k >= 0) o[k] = 1'b1;
    return o;
  endfunction

  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic new_wr(input int i);
    r_wv[i] = 1'b1;
    r_wa[i] = AW'($urandom());
    r_wd[i] = rnd_udw();
    r_wb[i] = BWW'($urandom());
  endtask

  task automatic new_rd(input int i);
    r_rv[i] = 1'b1;
    r_ra[i] = AW'($urandom());
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0;
    tagq.delete();
    e_wcmd = 0; e_rcmd = 0; e_terr = 0;
    e_wa = '0; e_ra = '0; e_wd = '0; e_rdata = '0; e_wb = '1; e_rdv = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    r_wv = '0; r_rv = '0; mig_rv = 1'b0;
    wr_valid = '0; rd_valid = '0; app.app_rd_valid = 1'b0;
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    chk("rst_wr_ready", 256'(wr_ready), 256'(0));
    chk("rst_wcmd", 256'(app.app_wr_cmd), 256'(0));
    chk("rst_bw_n", 256'(app.app_wr_bw_n), 256'({BWW{1'b1}}));
    chk("rst_tag_err", 256'(tag_err), 256'(0));
    sys_rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check against model, advance model.
  task automatic step();
    int ww, rw, t;
    logic full;
    for (int i = 0; i < N; i++) begin
      wr_valid[i] = r_wv[i];
      rd_valid[i] = r_rv[i];
      wr_addr[i*AW +: AW]    = r_wa[i];
      rd_addr[i*AW +: AW]    = r_ra[i];
      wr_data[i*UDW +: UDW]  = r_wd[i];
      wr_bw_n[i*BWW +: BWW]  = r_wb[i];
    end
    app.app_rd_valid = mig_rv;
    app.app_rd_data  = mig_rd;
    #1;
    full = (tagq.size() >= RDO);
    ww = cal_done ? rr(r_wv, m_wp) : -1;
    rw = (cal_done && !full) ? rr(r_rv, m_rp) : -1;
    o_wr_ready = wr_ready; o_rd_ready = rd_ready; o_rdv = rd_data_valid;
    o_wcmd = app.app_wr_cmd; o_rcmd = app.app_rd_cmd; o_terr = tag_err; o_rdata = rd_data;
    chk("wr_ready", 256'(wr_ready), 256'(onehot(ww)));
    chk("rd_ready", 256'(rd_ready), 256'(onehot(rw)));
    chk("app_wr_cmd", 256'(app.app_wr_cmd), 256'(e_wcmd));
    chk("app_wr_addr", 256'(app.app_wr_addr), 256'(e_wa));
    chk("app_wr_data", 256'(app.app_wr_data), 256'(e_wd));
    chk("app_wr_bw_n", 256'(app.app_wr_bw_n), 256'(e_wb));
    chk("app_rd_cmd", 256'(app.app_rd_cmd), 256'(e_rcmd));
    chk("app_rd_addr", 256'(app.app_rd_addr), 256'(e_ra));
    chk("rd_data_valid", 256'(rd_data_valid), 256'(e_rdv));
    chk("rd_data", 256'(rd_data), 256'(e_rdata));
    chk("tag_err", 256'(tag_err), 256'(e_terr));
    e_rdv = '0;
    if (mig_rv) begin
      if (tagq.size() > 0) begin
        t = tagq.pop_front();
        e_rdv = onehot(t);
        e_rdata = mig_rd;
      end else e_terr = 1'b1;
    end
    e_wcmd = (ww >= 0);
    if (ww >= 0) begin
      e_wa = r_wa[ww]; e_wd = r_wd[ww]; e_wb = r_wb[ww];
      m_wp = (ww + 1) % N;
      r_wv[ww] = 1'b0;
    end
    e_rcmd = (rw >= 0);
    if (rw >= 0) begin
      e_ra = r_ra[rw];
      m_rp = (rw + 1) % N;
      tagq.push_back(rw);
      r_rv[rw] = 1'b0;
    end
    mig_rv = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
  endtask

  logic [N-1:0]   g [4];
  logic           wc [5];
  logic [UDW-1:0] d0, d1;

  initial begin
    cal_done = 1'b0;
    mig_rd = '0;
    for (int i = 0; i < N; i++) begin
      r_wa[i] = '0; r_ra[i] = '0; r_wd[i] = '0; r_wb[i] = '1;
    end
    do_reset();

    // cal_done low blocks reads; first grant after calibration goes to req 0
    r_rv = '1;
    repeat (3) step();
    chk("cal_blk_rdy", 256'(o_rd_ready), 256'(0));
    chk("cal_blk_cmd", 256'(o_rcmd), 256'(0));
    cal_done = 1'b1;
    step();
    chk("cal_first_grant", 256'(o_rd_ready), 256'(2'b01));

    // both writers held high: grants alternate, one command per cycle
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) for (int i = 0; i < N; i++) if (!r_wv[i]) new_wr(i);
      step();
      if (c < 4) g[c] = o_wr_ready;
      wc[c] = o_wcmd;
    end
    chk("wr_alt0", 256'(g[0]), 256'(2'b01));
    chk("wr_alt1", 256'(g[1]), 256'(2'b10));
    chk("wr_alt2", 256'(g[2]), 256'(2'b01));
    chk("wr_alt3", 256'(g[3]), 256'(2'b10));
    for (int c = 1; c < 5; c++) chk("wr_cmd_pulse", 256'(wc[c]), 256'(1));
    r_wv = '0;

    // in-order return steered to the issuing requester
    do_reset();
    d0 = rnd_udw(); d1 = rnd_udw();
    r_rv[1] = 1'b1; r_ra[1] = 18'h10; step();
    r_rv[0] = 1'b1; r_ra[0] = 18'h20; step();
    mig_rv = 1'b1; mig_rd = d1; step();
    mig_rv = 1'b1; mig_rd = d0; step();
    chk("ret_first_dv", 256'(o_rdv), 256'(2'b10));
    chk("ret_first_data", 256'(o_rdata), 256'(d1));
    step();
    chk("ret_second_dv", 256'(o_rdv), 256'(2'b01));
    chk("ret_second_data", 256'(o_rdata), 256'(d0));

    // tag FIFO full blocks the 17th read; one return reopens a cycle later
    do_reset();
    for (int i = 0; i < RDO; i++) begin
      r_rv[0] = 1'b1; r_ra[0] = AW'(i); step();
    end
    r_rv[0] = 1'b1; step();
    chk("full_block", 256'(o_rd_ready), 256'(0));
    mig_rv = 1'b1; mig_rd = rnd_udw(); step();
    chk("full_prepop", 256'(o_rd_ready), 256'(0));
    step();
    chk("full_reopen", 256'(o_rd_ready), 256'(2'b01));
    for (int i = 0; i < RDO + 4; i++) begin
      mig_rv = (tagq.size() > 0); mig_rd = rnd_udw(); step();
    end

    // unexpected read data sets a sticky error
    do_reset();
    mig_rv = 1'b1; step(); step();
    chk("terr_set", 256'(o_terr), 256'(1));
    chk("terr_no_dv", 256'(o_rdv), 256'(0));
    repeat (3) step();
    chk("terr_sticky", 256'(o_terr), 256'(1));
    do_reset();
    step();
    chk("terr_clear", 256'(o_terr), 256'(0));
    r_rv[0] = 1'b1; step();
    do_reset();
    mig_rv = 1'b1; step(); step();
    chk("terr_after_rst", 256'(o_terr), 256'(1));

    // write and read issue in the same cycle
    do_reset();
    new_wr(1); new_rd(0); step(); step();
    chk("both_wcmd", 256'(o_wcmd), 256'(1));
    chk("both_rcmd", 256'(o_rcmd), 256'(1));

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cal_done = ($urandom_range(99, 0) < 92);
      for (int i = 0; i < N; i++) begin
        if (!r_wv[i] && $urandom_range(2, 0) == 0) new_wr(i);
        if (!r_rv[i] && $urandom_range(1, 0) == 0) new_rd(i);
      end
      mig_rv = (tagq.size() > 0) &&
               ($urandom_range(99, 0) < (((c / 400) % 2) ? 15 : 60));
      mig_rd = rnd_udw();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/qdr_user_arb.md
Name: qdr_user_arb

Overview:
- Shares the QDRII+ MIG user interface (example_top command/data channel) between NUM_REQ local requesters.
- Independent round-robin arbiters for the write and read channels, so one write and one read can issue in the same cycle, matching QDR's separate ports.
- Read data returns in order; a tag FIFO steers each returned burst to the requester that issued it.
- Sits between the packet-buffer clients and the MIG user interface, inside the sys_clk domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 18, QDR burst address width.
- DATA_WIDTH, 36, QDR device data width.
- BW_WIDTH, 4, byte-write lanes per device word.
- BURST_LEN, 4, QDR burst length; user data width is BURST_LEN*DATA_WIDTH (UDW).
- RD_OUTSTANDING, 16, tag FIFO depth (power of 2).

Ports:
- sys_clk  in  1  user-interface clock; single clock domain.
- sys_rst  in  1  synchronous active-high reset.
- cal_done  in  1  MIG calibration complete.
- wr_valid  in  NUM_REQ  per-requester write request.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  write addresses; requester i at slice i.
- wr_data  in  NUM_REQ*UDW  write data.
- wr_bw_n  in  NUM_REQ*BURST_LEN*BW_WIDTH  active-low byte enables.
- wr_ready  out  NUM_REQ  write accepted this cycle.
- rd_valid  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  read addresses.
- rd_ready  out  NUM_REQ  read accepted this cycle.
- rd_data  out  UDW  returned read data, broadcast to all requesters.
- rd_data_valid  out  NUM_REQ  one-hot qualifier for rd_data.
- app_wr_cmd  out  1  MIG write command strobe.
- app_wr_addr  out  ADDR_WIDTH  MIG write address.
- app_wr_data  out  UDW  MIG write data.
- app_wr_bw_n  out  BURST_LEN*BW_WIDTH  MIG byte enables.
- app_rd_cmd  out  1  MIG read command strobe.
- app_rd_addr  out  ADDR_WIDTH  MIG read address.
- app_rd_valid  in  1  MIG read data valid.
- app_rd_data  in  UDW  MIG read data.
- tag_err  out  1  sticky error: read data arrived with no outstanding tag.

Behaviour:
- Reset: all outputs 0, except app_wr_bw_n which resets to all-ones. Both round-robin pointers point to requester 0; tag FIFO empty; tag_err cleared. Reset mid-operation drops all outstanding tags, and read data returned after reset sets tag_err.
- Write arbiter:
  - Eligible when cal_done=1.
  - Winner = first requester with wr_valid set, searching from wr_ptr upward with wrap.
  - wr_ready[winner] is asserted combinationally in the same cycle. The handshake is valid&ready.
  - Next cycle: app_wr_cmd=1 with the registered addr/data/bw_n of the winner. Latency is exactly 1 cycle.
  - On a grant, wr_ptr moves to winner+1, wrapping at NUM_REQ-1 to 0. Without a grant the pointer holds.
- Read arbiter:
  - Same algorithm with rd_ptr.
  - Additionally requires the tag FIFO not full.
  - On a grant, push the winner index into the tag FIFO; the next cycle drives app_rd_cmd=1 with app_rd_addr.
- Read return:
  - app_rd_valid=1 with tag FIFO non-empty: pop the FIFO.
  - Register the data: rd_data <= app_rd_data, and rd_data_valid <= one-hot(popped tag). Latency 1 cycle.
  - app_rd_valid=1 with tag FIFO empty: set tag_err; rd_data_valid stays 0.
- Simultaneous push and pop are allowed in the same cycle, including when the FIFO is full. A pop while full frees a slot, but the full flag is registered, so the read grant uses the pre-pop full state.
- cal_done=0: no grants and no commands. Outstanding reads still drain.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.
- The write and read channels never block each other.

Optional Feature:
- Macro: QDR_USER_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_wr_cnt[31:0], perf_rd_cnt[31:0] and perf_stall_cnt[31:0], plus input perf_clr.
  - perf_wr_cnt and perf_rd_cnt count issued commands.
  - perf_stall_cnt counts cycles where any rd_valid is asserted but reads are blocked by tag FIFO full or cal_done=0.
  - Counters saturate at all-ones. perf_clr and sys_rst zero them.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package qdr_arb_pkg holds:
  - UDW and BWW derivation constants;
  - TAG_W = clog2(NUM_REQ);
  - a round-robin winner function shared by both arbiters.
- One sub-module, qdr_arb_tag_fifo:
  - synchronous FIFO, width TAG_W, depth RD_OUTSTANDING;
  - registered full/empty flags.

Test Plan:
- Both wr_valid held high for 4 cycles after cal_done → wr_ready grants 0,1,0,1; app_wr_cmd pulses each cycle, and addresses alternate with 1-cycle latency.
- cal_done=0 with rd_valid=2'b11 → no rd_ready and no app_rd_cmd. After cal_done rises, the first grant goes to requester 0.
- Reads issued by req1 then req0 (addr 0x10, 0x20), and the model returns D1 then D0 → rd_data_valid=2'b10 with D1, then 2'b01 with D0.
- 16 reads issued with no return → the 17th rd_valid sees rd_ready=0. One app_rd_valid pulse re-enables the grant on the following cycle.
- app_rd_valid with no outstanding read → tag_err=1 and stays set until sys_rst; rd_data_valid=0.
- Same-cycle wr_valid[1] and rd_valid[0] → app_wr_cmd and app_rd_cmd both assert in the next cycle.
